// File: rtl/serial_frame_tx.sv
// serial_frame_tx
//   Latches a parallel word on a start request and sends it on a single-bit
//   line as a start bit (0), DATA_W data bits LSB first, an optional parity
//   bit and STOP_BITS stop bits (1). Every bit is held for CLKS_PER_BIT clocks.
//
// Parameters
//   DATA_W       data bits per frame (1..32)
//   CLKS_PER_BIT clocks per bit time (>=1)
//   STOP_BITS    number of stop bits (1 or 2)
//   PARITY_EN    1 = parity bit after the data bits
//   PARITY_ODD   0 = even parity, 1 = odd parity
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; aborts a frame in flight
//   start      frame request, only sampled while idle
//   d          parallel data, captured on the accepting edge
//   busy       high while a frame is on the line
//   y          serial line, idles high
//   done       one-cycle pulse in the idle cycle after the last stop bit
//   state_dbg  current FSM state (0 idle, 1 start, 2 data, 3 parity, 4 stop)
//
// Handshake: start is a single-cycle request. It is accepted on any rising
// edge where the FSM is idle (including the done cycle) and reset is low;
// requests while busy are dropped, never queued.
module serial_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] d,
  output logic              busy,
  output logic              y,
  output logic              done,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
  // A single stop-index bit is enough for one or two stop bits.
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  // Seeding the accumulator with the odd flag folds the odd/even choice in.
  localparam logic          PAR_INIT  = (PARITY_ODD != 0);
  localparam logic          HAS_PAR   = (PARITY_EN != 0);

  state_t            state, state_nx;
  logic [DATA_W-1:0] shift;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bit_idx;
  logic              stop_idx;
  logic              par;
  logic              done_q;

  logic bit_end;
  logic last_data;
  logic last_stop;

  assign bit_end   = (cnt == CNT_LAST);
  assign last_data = (bit_idx == BIT_LAST);
  assign last_stop = (stop_idx == STOP_LAST);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      shift    <= '0;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par      <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= (state == S_STOP) && bit_end && last_stop;

      if (state == S_IDLE) begin
        if (start) begin
          shift    <= d;
          cnt      <= '0;
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          par      <= PAR_INIT;
        end
      end else begin
        cnt <= bit_end ? '0 : cnt + 1'b1;

        if (state == S_DATA && bit_end) begin
          shift   <= shift >> 1;
          par     <= par ^ shift[0];
          bit_idx <= last_data ? '0 : bit_idx + 1'b1;
        end

        if (state == S_STOP && bit_end) begin
          stop_idx <= last_stop ? 1'b0 : stop_idx + 1'b1;
        end
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (start) state_nx = S_START;
      S_START:  if (bit_end) state_nx = S_DATA;
      S_DATA:   if (bit_end && last_data) state_nx = HAS_PAR ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_nx = S_STOP;
      S_STOP:   if (bit_end && last_stop) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Outputs decoded from registers only.
  always_comb begin
    y    = 1'b1;
    busy = 1'b1;
    unique case (state)
      S_IDLE:   busy = 1'b0;
      S_START:  y = 1'b0;
      S_DATA:   y = shift[0];
      S_PARITY: y = par;
      S_STOP:   y = 1'b1;
      default:  busy = 1'b0;
    endcase
  end

  assign done      = done_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_serial_frame_tx.sv
module tb_serial_frame_tx;

  localparam int N = 6;
  // Configurations: defaults, even parity, odd parity, 5-bit/1-clk/2-stop,
  // 1-bit/3-clk/2-stop/odd parity, 32-bit/1-clk/even parity.
  localparam int W_A[N] = '{8, 8, 8, 5, 1, 32};
  localparam int C_A[N] = '{4, 4, 4, 1, 3, 1};
  localparam int S_A[N] = '{1, 1, 1, 2, 2, 1};
  localparam int P_A[N] = '{0, 1, 1, 0, 1, 1};
  localparam int O_A[N] = '{0, 0, 1, 0, 1, 0};

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] d;
  logic [N-1:0] y_v, busy_v, done_v;
  logic [2:0]  st_v [N];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    serial_frame_tx #(
      .DATA_W      (W_A[gi]),
      .CLKS_PER_BIT(C_A[gi]),
      .STOP_BITS   (S_A[gi]),
      .PARITY_EN   (P_A[gi]),
      .PARITY_ODD  (O_A[gi])
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .d        (d[W_A[gi]-1:0]),
      .busy     (busy_v[gi]),
      .y        (y_v[gi]),
      .done     (done_v[gi]),
      .state_dbg(st_v[gi])
    );
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: each instance is described by its position within the
  // current frame (-1 idle, 0..F-1 on the line, F the done cycle) and the
  // list of bits the frame should carry.
  int          pos   [N];
  logic [63:0] fbits [N];

  // Words the default instance should deliver, checked by a line receiver.
  logic [31:0] exp_q[$];
  logic [7:0]  rx_word;

  function automatic int frame_len(input int i);
    return (1 + W_A[i] + P_A[i] + S_A[i]) * C_A[i];
  endfunction

  function automatic logic [63:0] make_frame(input int i, input logic [31:0] data);
    logic [63:0] v;
    logic        p;
    v    = '1;
    v[0] = 1'b0;
    p    = (O_A[i] != 0);
    for (int b = 0; b < W_A[i]; b++) begin
      v[1+b] = data[b];
      p      = p ^ data[b];
    end
    if (P_A[i] != 0) v[1+W_A[i]] = p;
    return v;
  endfunction

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        pos[i] = -1;
      end else if ((pos[i] < 0 || pos[i] == frame_len(i)) && start) begin
        fbits[i] = make_frame(i, d);
        pos[i]   = 0;
        if (i == 0) exp_q.push_back({24'd0, d[7:0]});
      end else if (pos[i] >= 0 && pos[i] < frame_len(i)) begin
        pos[i]++;
      end else begin
        pos[i] = -1;
      end
    end
    if (reset) exp_q.delete();
  endtask

  task automatic compare_all();
    logic ey, eb, ed;
    for (int i = 0; i < N; i++) begin
      eb = (pos[i] >= 0) && (pos[i] < frame_len(i));
      ed = (pos[i] == frame_len(i));
      ey = eb ? fbits[i][pos[i] / C_A[i]] : 1'b1;
      check($sformatf("y[%0d]", i),    {31'd0, y_v[i]},    {31'd0, ey});
      check($sformatf("busy[%0d]", i), {31'd0, busy_v[i]}, {31'd0, eb});
      check($sformatf("done[%0d]", i), {31'd0, done_v[i]}, {31'd0, ed});
      check($sformatf("done_and_busy[%0d]", i), {31'd0, done_v[i] & busy_v[i]}, 32'd0);
    end
    // Receiver on the default instance: sample each data bit mid-bit.
    if (pos[0] >= 4 && pos[0] < 36 && (pos[0] % 4) == 2)
      rx_word[pos[0] / 4 - 1] = y_v[0];
    if (pos[0] == frame_len(0)) begin
      check("rx_q_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) check("rx_word", {24'd0, rx_word}, exp_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse_start(input logic [31:0] data);
    d     = data;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < N; i++) begin
      pos[i]   = -1;
      fbits[i] = '1;
    end
    rx_word = '0;
    reset = 1'b1;
    start = 1'b1;   // reset must win over a simultaneous start
    d     = 32'hFFFF_FFFF;
    ticks(3);
    check("reset_y",    {26'd0, y_v},    {26'd0, {N{1'b1}}});
    check("reset_busy", {26'd0, busy_v}, 32'd0);
    check("reset_done", {26'd0, done_v}, 32'd0);
    reset = 1'b0;
    start = 1'b0;
    ticks(2);

    // Directed frames: A5 on defaults, 07 for parity, 10110 for the 5-bit line.
    pulse_start(32'h0000_00A5);
    ticks(50);
    pulse_start(32'h0000_0007);
    ticks(50);
    pulse_start(32'h0000_0016);
    ticks(50);

    // start held high with d changing every cycle.
    start = 1'b1;
    for (int k = 0; k < 300; k++) begin
      d = $urandom;
      tick();
    end
    start = 1'b0;
    ticks(50);

    // Reset during data bit 3 of the default frame (cycle pos 17).
    pulse_start(32'h0000_005C);
    ticks(17);
    reset = 1'b1;
    tick();
    check("rst_mid_y",    {31'd0, y_v[0]},    32'd1);
    check("rst_mid_busy", {31'd0, busy_v[0]}, 32'd0);
    check("rst_mid_done", {31'd0, done_v[0]}, 32'd0);
    reset = 1'b0;
    ticks(2);
    pulse_start(32'h0000_00C3);
    ticks(50);

    // start pulses and d changes while busy.
    pulse_start(32'h0000_0081);
    for (int k = 0; k < 30; k++) begin
      d     = $urandom;
      start = ($urandom_range(0, 2) == 0);
      tick();
    end
    start = 1'b0;
    ticks(50);

    // Random traffic with occasional resets.
    for (int k = 0; k < 4000; k++) begin
      d     = $urandom;
      start = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;
    start = 1'b0;
    ticks(60);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
